// File: rtl/comp_storage_if.sv
// Host command interface of the computational-storage engine.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready
// are both high; the host holds cmd_valid and all command fields stable until
// that edge, and the engine ignores every command input while cmd_ready is low.
// Completion is a one-cycle done pulse, with err/ovf/rd_data valid alongside it.
interface comp_storage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd;
  logic [ADDR_W-1:0] addA;
  logic [ADDR_W-1:0] addB;
  logic [ADDR_W-1:0] addC;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              err;
  logic              ovf;

  modport master (
    output cmd_valid, cmd, addA, addB, addC, wr_data,
    input  cmd_ready, rd_data, done, err, ovf
  );

  modport slave (
    input  cmd_valid, cmd, addA, addB, addC, wr_data,
    output cmd_ready, rd_data, done, err, ovf
  );
endinterface

// File: rtl/comp_storage_engine.sv
// Computational-storage engine: DEPTH x DATA_W register memory that executes
// RD/WR/ADD/SUB/ACC commands in place, with wrap or saturating arithmetic.
module comp_storage_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int SAT    = 0
) (
  input  logic                clk,
  input  logic                reset,
  comp_storage_if.slave       bus,
  output logic [1:0]          o_dbg_state
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_RD  = 3'd1;
  localparam logic [2:0] C_WR  = 3'd2;
  localparam logic [2:0] C_ADD = 3'd3;
  localparam logic [2:0] C_SUB = 3'd4;
  localparam logic [2:0] C_ACC = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACCUM, S_WB} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W-1:0] r_addc;
  logic [DATA_W-1:0] r_acc;
  logic              r_acc_ovf;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done;
  logic              r_err;
  logic              r_ovf;
  logic              r_ready;

  logic [DATA_W:0]   w_add_full;
  logic [DATA_W-1:0] w_add_res;
  logic              w_sub_borrow;
  logic [DATA_W-1:0] w_sub_res;
  logic [DATA_W:0]   w_acc_full;
  logic [DATA_W-1:0] w_acc_res;

  // Arithmetic datapath: carry/borrow detection plus optional clamping.
  always_comb begin
    w_add_full   = {1'b0, r_opa} + {1'b0, r_opb};
    w_add_res    = w_add_full[DATA_W-1:0];
    w_sub_borrow = (r_opa < r_opb);
    w_sub_res    = r_opa - r_opb;
    w_acc_full   = {1'b0, r_acc} + {1'b0, r_mem[r_idx]};
    w_acc_res    = w_acc_full[DATA_W-1:0];
    if (SAT != 0) begin
      if (w_add_full[DATA_W]) w_add_res = '1;
      if (w_sub_borrow)       w_sub_res = '0;
      if (w_acc_full[DATA_W]) w_acc_res = '1;
    end
  end

  // Command FSM, memory and registered completion outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_op      <= C_NOP;
      r_opa     <= '0;
      r_opb     <= '0;
      r_idx     <= '0;
      r_end     <= '0;
      r_addc    <= '0;
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
      r_rd_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ovf  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd)
              C_NOP: ;
              C_WR: begin
                r_mem[bus.addC] <= bus.wr_data;
                r_done          <= 1'b1;
              end
              C_RD, C_ADD, C_SUB: begin
                // Operands captured now, so addC overlapping addA/addB is safe.
                r_op    <= bus.cmd;
                r_opa   <= r_mem[bus.addA];
                r_opb   <= r_mem[bus.addB];
                r_addc  <= bus.addC;
                r_state <= S_EXEC;
                r_ready <= 1'b0;
              end
              C_ACC: begin
                if (bus.addB < bus.addA) begin
                  r_done <= 1'b1;
                  r_err  <= 1'b1;
                end else begin
                  r_idx     <= bus.addA;
                  r_end     <= bus.addB;
                  r_addc    <= bus.addC;
                  r_acc     <= '0;
                  r_acc_ovf <= 1'b0;
                  r_state   <= S_ACCUM;
                  r_ready   <= 1'b0;
                end
              end
              default: begin
                r_done <= 1'b1;
                r_err  <= 1'b1;
              end
            endcase
          end
        end
        S_EXEC: begin
          case (r_op)
            C_ADD: begin
              r_mem[r_addc] <= w_add_res;
              r_rd_data     <= w_add_res;
              r_ovf         <= w_add_full[DATA_W];
            end
            C_SUB: begin
              r_mem[r_addc] <= w_sub_res;
              r_rd_data     <= w_sub_res;
              r_ovf         <= w_sub_borrow;
            end
            default: r_rd_data <= r_opa;
          endcase
          r_done  <= 1'b1;
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        S_ACCUM: begin
          // One word per edge; reads see memory as it is right now.
          r_acc     <= w_acc_res;
          r_acc_ovf <= r_acc_ovf | w_acc_full[DATA_W];
          if (r_idx == r_end) r_state <= S_WB;
          else                r_idx   <= r_idx + 1'b1;
        end
        S_WB: begin
          r_mem[r_addc] <= r_acc;
          r_rd_data     <= r_acc;
          r_ovf         <= r_acc_ovf;
          r_done        <= 1'b1;
          r_state       <= S_IDLE;
          r_ready       <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.rd_data   = r_rd_data;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.ovf       = r_ovf;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_comp_storage_engine.sv
// Bench for comp_storage_engine: a wrapping (SAT=0) and a saturating (SAT=1)
// instance receive identical commands; a reference model predicts responses.
module tb_comp_storage_engine;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  localparam int RW = DW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  comp_storage_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  comp_storage_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
  logic [1:0] dbg0, dbg1;

  comp_storage_engine #(.DATA_W(DW), .ADDR_W(AW), .SAT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0), .o_dbg_state(dbg0));
  comp_storage_engine #(.DATA_W(DW), .ADDR_W(AW), .SAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1), .o_dbg_state(dbg1));

  assign if1.cmd_valid = if0.cmd_valid;
  assign if1.cmd       = if0.cmd;
  assign if1.addA      = if0.addA;
  assign if1.addB      = if0.addB;
  assign if1.addC      = if0.addC;
  assign if1.wr_data   = if0.wr_data;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q0[$];
  logic [RW-1:0] exp_q1[$];
  logic [DW-1:0] mem_m [2][DEPTH];
  logic [DW-1:0] last_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void arith(input bit sat, input bit is_sub, input logic [DW-1:0] x,
                                input logic [DW-1:0] y, output logic [DW-1:0] r, output bit o);
    int s;
    if (!is_sub) begin
      s = int'(x) + int'(y);
      o = (s > 65535);
      r = o ? (sat ? 16'hFFFF : 16'(s - 65536)) : 16'(s);
    end else begin
      s = int'(x) - int'(y);
      o = (s < 0);
      r = o ? (sat ? 16'h0000 : 16'(s + 65536)) : 16'(s);
    end
  endfunction

  task automatic model_cmd(input int k, input logic [2:0] c, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] cc, input logic [15:0] wd,
                           output logic [RW-1:0] e, output int busy, output bit has_done);
    logic [DW-1:0] r, acc;
    bit o, ov;
    has_done = 1'b1;
    busy = 0;
    e = {last_rd[k], 2'b00};
    case (c)
      3'd0: has_done = 1'b0;
      3'd1: begin
        last_rd[k] = mem_m[k][a];
        e = {last_rd[k], 2'b00};
        busy = 1;
      end
      3'd2: mem_m[k][cc] = wd;
      3'd3, 3'd4: begin
        arith(k == 1, c == 3'd4, mem_m[k][a], mem_m[k][b], r, o);
        mem_m[k][cc] = r;
        last_rd[k] = r;
        e = {r, 1'b0, o};
        busy = 1;
      end
      3'd5: begin
        if (b < a) begin
          e = {last_rd[k], 2'b10};
        end else begin
          acc = '0;
          ov = 1'b0;
          for (int i = int'(a); i <= int'(b); i++) begin
            arith(k == 1, 1'b0, acc, mem_m[k][i], acc, o);
            ov = ov | o;
          end
          mem_m[k][cc] = acc;
          last_rd[k] = acc;
          e = {acc, 1'b0, ov};
          busy = int'(b) - int'(a) + 2;
        end
      end
      default: e = {last_rd[k], 2'b10};
    endcase
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (!reset) begin
      if (if0.done) begin
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL done0_unexpected actual=1 expected=0 at %0t", $time);
        end else begin
          e = exp_q0.pop_front();
          check("resp_sat0", 32'({if0.rd_data, if0.err, if0.ovf}), 32'(e));
        end
      end
      if (if1.done) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL done1_unexpected actual=1 expected=0 at %0t", $time);
        end else begin
          e = exp_q1.pop_front();
          check("resp_sat1", 32'({if1.rd_data, if1.err, if1.ovf}), 32'(e));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left on a falling edge; ready seen here is what the next rising edge samples.
  task automatic do_cmd(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] cc, input logic [15:0] wd, input bit garble);
    int busy_exp, busy, w;
    logic [RW-1:0] e0, e1;
    bit hd;
    if0.cmd = c; if0.addA = a; if0.addB = b; if0.addC = cc; if0.wr_data = wd;
    if0.cmd_valid = 1'b1;
    w = 0;
    while (!if0.cmd_ready && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (!if0.cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 expected=1 at %0t", $time);
      if0.cmd_valid = 1'b0;
      return;
    end
    model_cmd(0, c, a, b, cc, wd, e0, busy_exp, hd);
    model_cmd(1, c, a, b, cc, wd, e1, busy_exp, hd);
    if (hd) begin
      exp_q0.push_back(e0);
      exp_q1.push_back(e1);
    end
    @(posedge clk);
    @(negedge clk);
    if0.cmd_valid = 1'b0;
    busy = 0;
    while (!if0.cmd_ready && busy < 4000) begin
      if (garble) begin
        if0.cmd_valid = 1'b1;
        if0.cmd = 3'($urandom_range(1, 7));
        if0.addA = 8'($urandom_range(0, 255));
        if0.addB = 8'($urandom_range(0, 255));
        if0.addC = 8'($urandom_range(0, 255));
        if0.wr_data = 16'($urandom_range(0, 65535));
      end
      busy++;
      @(negedge clk);
    end
    if0.cmd_valid = 1'b0;
    check("busy_cycles", 32'(busy), 32'(busy_exp));
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) mem_m[k][i] = '0;
      last_rd[k] = '0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] a, b;
    logic [15:0] wd;
    reset = 1'b1;
    if0.cmd_valid = 1'b0; if0.cmd = '0; if0.addA = '0; if0.addB = '0;
    if0.addC = '0; if0.wr_data = '0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready0", 32'(if0.cmd_ready), 32'd1);
    check("rst_ready1", 32'(if1.cmd_ready), 32'd1);
    check("rst_out0", 32'({if0.rd_data, if0.done, if0.err, if0.ovf}), 32'd0);
    check("rst_out1", 32'({if1.rd_data, if1.done, if1.err, if1.ovf}), 32'd0);

    // directed cases
    do_cmd(3'd1, 8'h10, 8'h00, 8'h00, 16'h0, 1'b0);
    do_cmd(3'd2, 8'h00, 8'h00, 8'h01, 16'h1234, 1'b0);
    do_cmd(3'd2, 8'h00, 8'h00, 8'h02, 16'h0F0F, 1'b0);
    do_cmd(3'd3, 8'h01, 8'h02, 8'h03, 16'h0, 1'b1);
    do_cmd(3'd1, 8'h03, 8'h00, 8'h00, 16'h0, 1'b0);
    do_cmd(3'd2, 8'h00, 8'h00, 8'h01, 16'hFFFF, 1'b0);
    do_cmd(3'd2, 8'h00, 8'h00, 8'h02, 16'h0002, 1'b0);
    do_cmd(3'd3, 8'h01, 8'h02, 8'h04, 16'h0, 1'b0);
    do_cmd(3'd4, 8'h02, 8'h01, 8'h05, 16'h0, 1'b0);
    do_cmd(3'd1, 8'h04, 8'h00, 8'h00, 16'h0, 1'b0);
    do_cmd(3'd1, 8'h05, 8'h00, 8'h00, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) do_cmd(3'd2, 8'h00, 8'h00, 8'(8'h20 + i), 16'(i + 1), 1'b0);
    do_cmd(3'd5, 8'h20, 8'h23, 8'h20, 16'h0, 1'b1);
    do_cmd(3'd1, 8'h20, 8'h00, 8'h00, 16'h0, 1'b0);
    do_cmd(3'd5, 8'h05, 8'h04, 8'h05, 16'h0, 1'b0);
    do_cmd(3'd1, 8'h05, 8'h00, 8'h00, 16'h0, 1'b0);
    do_cmd(3'd7, 8'h01, 8'h02, 8'h03, 16'h0, 1'b0);
    do_cmd(3'd6, 8'h01, 8'h02, 8'h03, 16'h0, 1'b0);
    do_cmd(3'd0, 8'h01, 8'h02, 8'h03, 16'h0, 1'b0);
    do_cmd(3'd3, 8'h03, 8'h03, 8'h03, 16'h0, 1'b0);
    do_cmd(3'd1, 8'h03, 8'h00, 8'h00, 16'h0, 1'b0);
    do_cmd(3'd5, 8'h00, 8'hFF, 8'h07, 16'h0, 1'b1);
    do_cmd(3'd1, 8'h07, 8'h00, 8'h00, 16'h0, 1'b0);

    // randomized traffic in a small address window to force reuse and overlap
    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom_range(0, 31));
      b = 8'($urandom_range(0, 31));
      wd = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                                        : 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 9))
        0, 1, 2: do_cmd(3'd2, a, b, 8'($urandom_range(0, 31)), wd, 1'b0);
        3, 4:    do_cmd(3'd1, a, b, 8'($urandom_range(0, 31)), wd, 1'($urandom_range(0, 1)));
        5:       do_cmd(3'd3, a, b, 8'($urandom_range(0, 31)), wd, 1'($urandom_range(0, 1)));
        6:       do_cmd(3'd4, a, b, 8'($urandom_range(0, 31)), wd, 1'($urandom_range(0, 1)));
        7, 8: begin
          if ($urandom_range(0, 4) == 0 && a > 0) b = a - 8'd1;
          else b = a + 8'($urandom_range(0, 9));
          do_cmd(3'd5, a, b, 8'($urandom_range(0, 31)), wd, 1'($urandom_range(0, 1)));
        end
        default: do_cmd(3'($urandom_range(6, 7)), a, b, 8'(a + 1), wd, 1'b0);
      endcase
    end

    // long ACC aborted by reset on its 50th edge
    do_cmd(3'd2, 8'h00, 8'h00, 8'hF0, 16'hABCD, 1'b0);
    if0.cmd = 3'd5; if0.addA = 8'h00; if0.addB = 8'hC7; if0.addC = 8'hF0;
    if0.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.cmd_valid = 1'b0;
    check("abort_ready_low", 32'(if0.cmd_ready), 32'd0);
    repeat (48) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    check("post_rst_ready0", 32'(if0.cmd_ready), 32'd1);
    check("post_rst_ready1", 32'(if1.cmd_ready), 32'd1);
    check("post_rst_out0", 32'({if0.rd_data, if0.done, if0.err, if0.ovf}), 32'd0);
    check("post_rst_out1", 32'({if1.rd_data, if1.done, if1.err, if1.ovf}), 32'd0);
    for (int i = 0; i < DEPTH; i++) do_cmd(3'd1, 8'(i), 8'h00, 8'h00, 16'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so a stuck handshake cannot hang the run.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
